samp_clk_gen: RTL and testbench
===============================

SAMP_CLK_GEN -- requirements
Module: samp_clk_gen

Interface
REQ-001 The module SHALL have parameter CNT_W, default 32, meaning the width of the half-period counter and the divisor registers.
REQ-002 The module SHALL have parameter HALF_DEFAULT, default 50000, meaning the half-period in sys_clk cycles loaded at reset.
REQ-003 The module SHALL have the port sys_clk  in  1  system clock; all logic on its rising edge; one clock only.
REQ-004 The module SHALL have the port rst  in  1  reset, synchronous and active-high.
REQ-005 The module SHALL have the port en  in  1  run enable.
REQ-006 The module SHALL have the port div_val  in  CNT_W  requested half-period in sys_clk cycles.
REQ-007 The module SHALL have the port div_load  in  1  single-cycle request to capture div_val.
REQ-008 The module SHALL have the port div_ack  out  1  one-cycle pulse in the cycle a new half-period takes effect.
REQ-009 The module SHALL have the port samp_clk  out  1  divided sample clock, registered.
REQ-010 The module SHALL have the port samp_stb  out  1  one-cycle pulse in the same cycle samp_clk goes 0->1.
REQ-011 The module SHALL have the port half_cur  out  CNT_W  active half-period.

Function
REQ-012 The module SHALL contain a counter cnt; when run is active and cnt==half_cur-1, the counter SHALL toggle samp_clk and clear cnt, otherwise it SHALL increment cnt, so the period is 2*half_cur cycles at 50% duty.
REQ-013 samp_stb SHALL be asserted exactly in the cycles where samp_clk transitions 0->1, and SHALL never be asserted while samp_clk is falling or held.
REQ-014 When run is inactive (en=0, or burst idle per REQ-024), the module SHALL clear cnt and drive samp_clk=0 and samp_stb=0 from the next cycle; after re-activation, the first rising edge SHALL occur half_cur cycles later.
REQ-015 On div_load=1, the module SHALL capture div_val into a pending register and set pend_valid; a value of 0 SHALL be clamped to 1.
REQ-016 A pending value SHALL be applied to half_cur at the next toggle boundary (cnt==half_cur-1) while running, or on the next cycle while not running; div_ack SHALL pulse in that same cycle, and pend_valid SHALL clear.
REQ-017 If div_load arrives while pend_valid=1, the newer value SHALL replace the older one, and only one div_ack SHALL be issued.
REQ-018 If div_load coincides with a toggle boundary, the previously pending value (if any) SHALL be applied, and the new capture SHALL wait for the following boundary.
REQ-019 When half_cur=1, samp_clk SHALL toggle every cycle (sys_clk/2), and samp_stb SHALL pulse every 2 cycles.

Reset
REQ-020 On a cycle with rst=1, the module SHALL set cnt=0, samp_clk=0, samp_stb=0, div_ack=0, pend_valid=0, half_cur=HALF_DEFAULT, and the burst state to IDLE with burst_busy=0 and burst_done=0.
REQ-021 A reset asserted mid-period or mid-burst SHALL abort the operation with no trailing strobe, ack, or done pulse, and SHALL discard any pending divisor.

Configuration
REQ-022 With macro SAMP_BURST_EN defined, the module SHALL add ports burst_len (in, 16), burst_start (in, 1), burst_busy (out, 1), and burst_done (out, 1), plus an FSM with states IDLE, RUN, and DONE.
REQ-023 In the burst FSM, IDLE SHALL move to RUN on burst_start=1 with en=1, latching burst_len; RUN SHALL count samp_stb pulses and, after the Nth pulse, complete the high half-period, then enter DONE with samp_clk=0; DONE SHALL pulse burst_done for one cycle and return to IDLE.
REQ-024 With SAMP_BURST_EN defined, run SHALL be active only in RUN with en=1; burst_busy SHALL be 1 in RUN and DONE; burst_start while busy SHALL be ignored; burst_len=0 SHALL give DONE on the next cycle with zero strobes; en=0 during RUN SHALL return the FSM to IDLE without a burst_done pulse.
REQ-025 Without SAMP_BURST_EN, the burst ports and FSM SHALL be absent, and run SHALL equal en (free-running).

Verification
REQ-026 HALF_DEFAULT=4, release rst, en=1 -> the first samp_stb SHALL occur 4 cycles after en, followed by samp_stb every 8 cycles, with samp_clk high for 4 and low for 4.
REQ-027 Running at half_cur=4, div_load with div_val=2 at cnt=1 -> div_ack and half_cur=2 SHALL appear at the next boundary with no glitch, and the period SHALL then be 4 cycles.
REQ-028 div_load with div_val=0, then div_load with div_val=3 one cycle later before any boundary -> a single div_ack SHALL be issued and half_cur SHALL become 3; a separate load of 0 SHALL give half_cur=1 with samp_clk toggling every cycle.
REQ-029 en dropped while samp_clk=1 -> samp_clk=0 on the next cycle with no stb; a rst pulse mid-period SHALL restore half_cur=HALF_DEFAULT and samp_clk=0.
REQ-030 (SAMP_BURST_EN) burst_len=3 with burst_start -> exactly 3 samp_stb pulses, then one burst_done pulse and burst_busy low; burst_len=0 -> burst_done one cycle after start with no strobes.

Source files
------------

// File: rtl/samp_clk_gen.sv
// samp_clk_gen: programmable 50%-duty sample clock divider with glitch-free divisor update.
// Optional build macro SAMP_BURST_EN adds a burst sequencer (IDLE/RUN/DONE) that gates the run.
// Ports:
//   sys_clk     in  1      system clock, rising edge only
//   rst         in  1      synchronous active-high reset
//   en          in  1      run enable
//   div_val     in  CNT_W  requested half-period in sys_clk cycles (0 is treated as 1)
//   div_load    in  1      single-cycle request to capture div_val
//   burst_len   in  16     strobes per burst            (SAMP_BURST_EN only)
//   burst_start in  1      start a burst when idle      (SAMP_BURST_EN only)
//   burst_busy  out 1      burst in RUN or DONE         (SAMP_BURST_EN only)
//   burst_done  out 1      one-cycle end-of-burst pulse (SAMP_BURST_EN only)
//   div_ack     out 1      pulse in the cycle a new half-period takes effect
//   samp_clk    out 1      divided sample clock, registered
//   samp_stb    out 1      pulse in the cycle samp_clk rises
//   half_cur    out CNT_W  active half-period
module samp_clk_gen #(
    parameter int CNT_W        = 32,
    parameter int HALF_DEFAULT = 50000
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
`ifdef SAMP_BURST_EN
    input  logic [15:0]      burst_len,
    input  logic             burst_start,
    output logic             burst_busy,
    output logic             burst_done,
`endif
    output logic             div_ack,
    output logic             samp_clk,
    output logic             samp_stb,
    output logic [CNT_W-1:0] half_cur
);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(HALF_DEFAULT);

    logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, pend_q, pend_d;
    logic             clk_q, clk_d, stb_q, stb_d, ack_q, ack_d, pv_q, pv_d;
    logic             run, bnd, apply;

`ifdef SAMP_BURST_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} burst_state_t;
    burst_state_t st_q;
    logic [15:0]  rem_q;
    logic         busy_q, done_q;

    assign run = en && st_q == RUN;

    // rem_q counts strobes still owed; the burst ends on the falling
    // boundary that follows the last strobe, so the final high half completes.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            st_q   <= IDLE;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (st_q)
                IDLE: if (burst_start && en) begin
                    rem_q  <= burst_len;
                    st_q   <= (burst_len == '0) ? DONE : RUN;
                    busy_q <= 1'b1;
                    done_q <= burst_len == '0;
                end
                RUN: if (!en) begin
                    st_q   <= IDLE;
                    busy_q <= 1'b0;
                end else if (bnd && clk_q && rem_q == '0) begin
                    st_q   <= DONE;
                    done_q <= 1'b1;
                end else if (bnd && !clk_q) begin
                    rem_q <= rem_q - 16'd1;
                end
                default: begin
                    st_q   <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign burst_busy = busy_q;
    assign burst_done = done_q;
`else
    assign run = en;
`endif

    // A toggle boundary is the last cycle of a half-period; divisor changes
    // land only here (or while stopped) so no half-period is ever truncated.
    assign bnd   = run && cnt_q == half_q - ONE;
    assign apply = pv_q && (bnd || !run);

    always_comb begin
        cnt_d  = run ? (bnd ? '0 : cnt_q + ONE) : '0;
        clk_d  = run && (bnd ? !clk_q : clk_q);
        stb_d  = bnd && !clk_q;
        ack_d  = apply;
        half_d = apply ? pend_q : half_q;
        pend_d = div_load ? ((div_val == '0) ? ONE : div_val) : pend_q;
        // A load coinciding with an apply stays pending for the next boundary.
        pv_d   = div_load || (pv_q && !apply);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            stb_q  <= 1'b0;
            ack_q  <= 1'b0;
            pv_q   <= 1'b0;
            pend_q <= HALF_INIT;
            half_q <= HALF_INIT;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            stb_q  <= stb_d;
            ack_q  <= ack_d;
            pv_q   <= pv_d;
            pend_q <= pend_d;
            half_q <= half_d;
        end
    end

    assign div_ack  = ack_q;
    assign samp_clk = clk_q;
    assign samp_stb = stb_q;
    assign half_cur = half_q;
endmodule

// File: tb/tb_samp_clk_gen.sv
// tb_samp_clk_gen: randomized and directed self-checking bench for samp_clk_gen.
module tb_samp_clk_gen;
    logic        sys_clk, rst, en, div_load, div_ack, samp_clk, samp_stb;
    logic [15:0] div_val, half_cur;
`ifdef SAMP_BURST_EN
    logic [15:0] burst_len;
    logic        burst_start, burst_busy, burst_done;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: time is tracked as an absolute edge index; a toggle is
    // due when `half` edges of running have elapsed since the last restart point.
    int          m_n = 0, m_anchor = 0, m_st = 0;
    logic        m_level = 0, m_stb = 0, m_ack = 0, m_pv = 0, m_busy = 0, m_done = 0;
    logic [15:0] m_half = 16'd4, m_pend = 16'd4, m_rem = 0;

    samp_clk_gen #(.CNT_W(16), .HALF_DEFAULT(4)) dut (
        .sys_clk(sys_clk),
        .rst(rst),
        .en(en),
        .div_val(div_val),
        .div_load(div_load),
`ifdef SAMP_BURST_EN
        .burst_len(burst_len),
        .burst_start(burst_start),
        .burst_busy(burst_busy),
        .burst_done(burst_done),
`endif
        .div_ack(div_ack),
        .samp_clk(samp_clk),
        .samp_stb(samp_stb),
        .half_cur(half_cur)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [20:0] exp_v();
        return {m_level, m_stb, m_ack, m_half, m_busy, m_done};
    endfunction

    function automatic logic [20:0] act_v();
`ifdef SAMP_BURST_EN
        return {samp_clk, samp_stb, div_ack, half_cur, burst_busy, burst_done};
`else
        return {samp_clk, samp_stb, div_ack, half_cur, 2'b00};
`endif
    endfunction

    task automatic tick();
        logic run, bnd, apply, lvl_old;
        @(posedge sys_clk);
        m_n++;
        if (rst) begin
            m_level = 0; m_stb = 0; m_ack = 0; m_pv = 0; m_half = 16'd4;
            m_anchor = m_n; m_st = 0; m_busy = 0; m_done = 0;
        end else begin
`ifdef SAMP_BURST_EN
            run = en && m_st == 1;
`else
            run = en;
`endif
            lvl_old = m_level;
            bnd     = run && (m_n - m_anchor) == int'(m_half);
            apply   = m_pv && (bnd || !run);
            m_ack   = apply;
            if (apply) m_half = m_pend;
            m_level = run && (bnd ? !lvl_old : lvl_old);
            m_stb   = bnd && !lvl_old;
            if (!run || bnd) m_anchor = m_n;
            if (div_load) begin
                m_pend = (div_val == 0) ? 16'd1 : div_val;
                m_pv   = 1;
            end else if (apply) m_pv = 0;
`ifdef SAMP_BURST_EN
            case (m_st)
                0: if (burst_start && en) begin
                    m_rem = burst_len;
                    m_st  = (burst_len == 0) ? 2 : 1;
                end
                1: if (!en) m_st = 0;
                   else if (bnd && lvl_old && m_rem == 0) m_st = 2;
                   else if (bnd && !lvl_old) m_rem = m_rem - 16'd1;
                default: m_st = 0;
            endcase
            m_busy = m_st != 0;
            m_done = m_st == 2;
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; div_load = 0; div_val = 0;
`ifdef SAMP_BURST_EN
        burst_len = 0; burst_start = 0;
`endif
        tick(); tick();
        rst = 0;
        checks++; if (samp_clk !== 1'b0) begin errors++; $display("FAIL reset_clk got=%b exp=0", samp_clk); end
        checks++; if (samp_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b exp=0", samp_stb); end
        checks++; if (div_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", div_ack); end
        checks++; if (half_cur !== 16'd4) begin errors++; $display("FAIL reset_half got=%0d exp=4", half_cur); end
`ifdef SAMP_BURST_EN
        checks++; if ({burst_busy, burst_done} !== 2'b00) begin errors++; $display("FAIL reset_burst got=%b exp=00", {burst_busy, burst_done}); end
`endif
    endtask

    task automatic test_basic();
        int first = -1, last = -1;
        en = 1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++; if (act_v() !== exp_v()) begin errors++; $display("FAIL basic_cyc%0d got=%h exp=%h", i, act_v(), exp_v()); end
            if (samp_stb) begin
                if (first < 0) first = i;
                else begin
                    checks++; if (i - last != 8) begin errors++; $display("FAIL basic_period got=%0d exp=8", i - last); end
                end
                last = i;
            end
        end
        checks++; if (first != 4) begin errors++; $display("FAIL basic_first_stb got=%0d exp=4", first); end
    endtask

    task automatic test_div_change();
        int ack_at = -1, last = -1;
        for (int k = 0; k < 20 && (m_n - m_anchor) != 1; k++) tick();
        checks++; if ((m_n - m_anchor) != 1) begin errors++; $display("FAIL div_wait_cnt1 got=%0d exp=1", m_n - m_anchor); end
        div_val = 16'd2; div_load = 1; tick(); div_load = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++; if (act_v() !== exp_v()) begin errors++; $display("FAIL div_cyc%0d got=%h exp=%h", i, act_v(), exp_v()); end
            if (div_ack && ack_at < 0) ack_at = i;
            if (samp_stb && ack_at >= 0) begin
                if (last >= 0) begin
                    checks++; if (i - last != 4) begin errors++; $display("FAIL div_period got=%0d exp=4", i - last); end
                end
                last = i;
            end
        end
        checks++; if (ack_at != 2) begin errors++; $display("FAIL div_ack_time got=%0d exp=2", ack_at); end
        checks++; if (half_cur !== 16'd2) begin errors++; $display("FAIL div_half got=%0d exp=2", half_cur); end
    endtask

    task automatic test_coalesce();
        int acks = 0, stbs = 0;
        logic prev;
        div_val = 16'd8; div_load = 1; tick(); div_load = 0;
        for (int k = 0; k < 20 && half_cur !== 16'd8; k++) tick();
        checks++; if (half_cur !== 16'd8) begin errors++; $display("FAIL coal_setup got=%0d exp=8", half_cur); end
        div_val = 16'd0; div_load = 1; tick(); acks += int'(div_ack);
        div_val = 16'd3; tick(); acks += int'(div_ack);
        div_load = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            acks += int'(div_ack);
            checks++; if (act_v() !== exp_v()) begin errors++; $display("FAIL coal_cyc%0d got=%h exp=%h", i, act_v(), exp_v()); end
        end
        checks++; if (acks != 1) begin errors++; $display("FAIL coal_acks got=%0d exp=1", acks); end
        checks++; if (half_cur !== 16'd3) begin errors++; $display("FAIL coal_half got=%0d exp=3", half_cur); end
        div_val = 16'd0; div_load = 1; tick(); div_load = 0;
        for (int k = 0; k < 20 && half_cur !== 16'd1; k++) tick();
        checks++; if (half_cur !== 16'd1) begin errors++; $display("FAIL zero_half got=%0d exp=1", half_cur); end
        prev = samp_clk;
        for (int i = 1; i <= 8; i++) begin
            tick();
            stbs += int'(samp_stb);
            checks++; if (samp_clk !== !prev) begin errors++; $display("FAIL zero_toggle%0d got=%b exp=%b", i, samp_clk, !prev); end
            prev = samp_clk;
        end
        checks++; if (stbs != 4) begin errors++; $display("FAIL zero_stbs got=%0d exp=4", stbs); end
    endtask

    task automatic test_en_drop();
        int acks = 0;
        for (int k = 0; k < 10 && samp_clk !== 1'b1; k++) tick();
        checks++; if (samp_clk !== 1'b1) begin errors++; $display("FAIL drop_wait_high got=%b exp=1", samp_clk); end
        en = 0; tick();
        checks++; if ({samp_clk, samp_stb} !== 2'b00) begin errors++; $display("FAIL drop_clk_stb got=%b exp=00", {samp_clk, samp_stb}); end
        en = 1;
        repeat (5) tick();
        div_val = 16'd5; div_load = 1; tick(); div_load = 0;
        rst = 1; tick(); rst = 0;
        checks++; if (half_cur !== 16'd4) begin errors++; $display("FAIL rst_half got=%0d exp=4", half_cur); end
        checks++; if ({samp_clk, samp_stb, div_ack} !== 3'b000) begin errors++; $display("FAIL rst_outs got=%b exp=000", {samp_clk, samp_stb, div_ack}); end
        for (int i = 1; i <= 12; i++) begin
            tick();
            acks += int'(div_ack);
            checks++; if (act_v() !== exp_v()) begin errors++; $display("FAIL rst_cyc%0d got=%h exp=%h", i, act_v(), exp_v()); end
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL rst_discard acks=%0d exp=0", acks); end
    endtask

`ifdef SAMP_BURST_EN
    task automatic test_burst();
        int stbs = 0, dones = 0, k = 0;
        rst = 1; tick(); rst = 0;
        en = 1; burst_len = 16'd3; burst_start = 1; tick(); burst_start = 0;
        while (k < 100 && !burst_done) begin
            tick(); k++;
            stbs += int'(samp_stb);
            checks++; if (act_v() !== exp_v()) begin errors++; $display("FAIL burst_cyc%0d got=%h exp=%h", k, act_v(), exp_v()); end
        end
        dones += int'(burst_done);
        checks++; if (!burst_done) begin errors++; $display("FAIL burst_timeout got=%b exp=1", burst_done); end
        tick();
        dones += int'(burst_done);
        checks++; if (stbs != 3) begin errors++; $display("FAIL burst_stbs got=%0d exp=3", stbs); end
        checks++; if (dones != 1) begin errors++; $display("FAIL burst_dones got=%0d exp=1", dones); end
        checks++; if (burst_busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end got=%b exp=0", burst_busy); end
        burst_len = 16'd0; burst_start = 1; tick(); burst_start = 0;
        checks++; if ({burst_done, burst_busy, samp_stb} !== 3'b110) begin errors++; $display("FAIL burst0 got=%b exp=110", {burst_done, burst_busy, samp_stb}); end
        tick();
        checks++; if ({burst_done, burst_busy} !== 2'b00) begin errors++; $display("FAIL burst0_end got=%b exp=00", {burst_done, burst_busy}); end
    endtask
`endif

    task automatic test_random();
        for (int i = 1; i <= 1500; i++) begin
            rst      = ($urandom_range(199) == 0);
            if ($urandom_range(29) == 0) en = !en;
            div_load = ($urandom_range(19) == 0);
            div_val  = 16'($urandom_range(6));
`ifdef SAMP_BURST_EN
            burst_start = ($urandom_range(39) == 0);
            burst_len   = 16'($urandom_range(3));
`endif
            tick();
            checks++; if (act_v() !== exp_v()) begin errors++; $display("FAIL rand_cyc%0d got=%h exp=%h", i, act_v(), exp_v()); end
        end
    endtask

    initial begin
        test_reset();
`ifdef SAMP_BURST_EN
        test_burst();
`else
        test_basic();
        test_div_change();
        test_coalesce();
        test_en_drop();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
